// File: rtl/ifetch_prefetch.sv
// ============================================================================
// Module   : ifetch_prefetch
// Purpose  : Instruction-fetch front end. It owns the PC, issues word fetches,
//            buffers in-order responses in a FWFT FIFO, and flushes on redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifetch_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          CNT_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_jump,
    input  logic        redirect_branch,
    input  logic [31:0] redirect_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26
);

    localparam int               c_aw    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_resp_pc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [31:0]      r_mem_data [DEPTH];
    logic [31:0]      r_mem_pc   [DEPTH];

    logic             w_redirect;
    logic [31:0]      w_pc4;
    logic [31:0]      w_br_off;
    logic [31:0]      w_target;
    logic [CNT_W:0]   w_inflight;
    logic             w_req_fire;
    logic             w_drop;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_drop_load;

    assign w_redirect  = redirect_jump | redirect_branch;
    assign w_pc4       = redirect_pc + 32'd4;
    assign w_br_off    = {{14{imm16[15]}}, imm16, 2'b00};
    assign w_target    = redirect_jump ? {w_pc4[31:28], addr26, 2'b00}
                                       : (w_pc4 + w_br_off);

    // Outstanding requests reserve FIFO space so a response can never overflow it.
    assign w_inflight     = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !reset && (w_inflight < {1'b0, c_depth}) && !w_redirect;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_drop      = imem_resp_valid && (r_state == ST_DRAIN);
    assign w_push      = imem_resp_valid && !w_drop;
    assign w_drop_load = r_outstanding - CNT_W'(imem_resp_valid);

    assign inst_valid  = !reset && (r_count != '0);
    assign w_pop       = inst_valid && inst_ready;
    assign inst        = inst_valid ? r_mem_data[r_rptr] : 32'h0;
    assign inst_pc     = inst_valid ? r_mem_pc[r_rptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_resp_valid);
            if (w_redirect) begin
                // Everything still in flight is now stale, including newly stale requests.
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_drop_cnt <= w_drop_load;
                r_state    <= (w_drop_load != '0) ? ST_DRAIN : ST_RUN;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                    if (r_drop_cnt == CNT_W'(1)) begin
                        r_state <= ST_RUN;
                    end
                end
                if (w_push) begin
                    r_wptr    <= r_wptr + c_aw'(1);
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_aw'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_redirect && !reset) begin
            r_mem_data[r_wptr] <= imem_resp_data;
            r_mem_pc[r_wptr]   <= r_resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_push && !w_redirect && (r_count == c_depth)));
            assert (w_inflight <= {1'b0, c_depth});
            assert (r_drop_cnt <= r_outstanding);
        end
    end

endmodule

`default_nettype wire

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction-fetch front end with a prefetch buffer. Sits upstream of the control/decode block.
- Owns the program counter and issues sequential word fetches to a variable-latency instruction memory over a valid/ready request port.
- Buffers in-order responses in a small FIFO and presents them downstream with a valid/ready handshake.
- Flushes and redirects on jumps and taken branches resolved by control.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2).
- CNT_W, 3, width of the occupancy/outstanding counters (log2(DEPTH)+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  byte address of fetch (word aligned).
- imem_resp_valid  in  1  response data valid; responses arrive in request order, ≥1 cycle after acceptance.
- imem_resp_data  in  32  fetched instruction word.
- inst_valid  out  1  inst/inst_pc valid for decode.
- inst_ready  in  1  decode consumes the head entry.
- inst  out  32  instruction word.
- inst_pc  out  32  byte address of inst.
- redirect_jump  in  1  jump resolved this cycle.
- redirect_branch  in  1  taken branch resolved this cycle.
- redirect_pc  in  32  PC of the resolving instruction.
- imm16  in  16  branch offset (words, signed).
- addr26  in  26  jump target field.

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=RUN.
  - imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0 during and one cycle after the reset edge.
  - Reset mid-transaction: pending responses are not tracked. The memory is reset by the same signal.
- Request issue:
  - imem_req_valid = !reset && (count + outstanding < DEPTH) && !redirect.
  - imem_req_addr = fetch_pc.
  - On accept (valid && ready), fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC→0) and outstanding increments.
- Response handling:
  - Each imem_resp_valid decrements outstanding.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise the data and its PC are written to the FIFO tail. A per-entry PC is captured from a shadow counter resp_pc, which is advanced by 4 per non-dropped response.
  - Write-to-output latency: a response at cycle k gives inst_valid at k+1.
- Output:
  - First-word-fall-through. inst_valid = (count>0).
  - inst and inst_pc are the head entry. Pop on inst_valid && inst_ready.
  - Simultaneous push and pop leave count unchanged. Simultaneous pop at count=DEPTH is legal. Push when full never occurs, by the issue rule (assertion).
- Redirect (redirect = redirect_jump | redirect_branch):
  - Jump has priority when both are set.
  - Jump target: {redirect_pc+4 [31:28], addr26, 2'b00}.
  - Branch target: redirect_pc + 4 + (sign_extend(imm16) << 2), modulo 2^32.
  - On the redirect edge: FIFO cleared (any same-cycle pop/push ignored); fetch_pc=resp_pc=target.
  - drop_cnt = outstanding − (resp_valid this cycle ? 1 : 0). No request is issued in the redirect cycle.
  - State → DRAIN if drop_cnt>0, else RUN. First request to the target is issued the cycle after the redirect.
  - inst_valid=0 in the cycle after a redirect.
- States:
  - RUN: drop_cnt==0.
  - DRAIN: drop_cnt>0. New requests may issue. DRAIN→RUN when the last stale response is dropped.
  - A redirect during DRAIN reloads drop_cnt per the formula above (stale plus newly stale).
- Invariants: count + outstanding ≤ DEPTH; drop_cnt ≤ outstanding.

Test Plan:
- Reset, RESET_PC=0, memory ready always, 1-cycle latency, inst_ready=1 → requests at 0,4,8,…; inst_pc sequence 0,4,8 with one instruction per cycle after a 2-cycle fill; inst_valid=0 in the cycle after reset.
- inst_ready=0 for 10 cycles → exactly 4 entries buffered, imem_req_valid low, PCs 0..C held. On release, drains in order, then issue resumes at 0x10.
- Memory latency 3 cycles with 2 requests in flight at addr 0x20/0x24; redirect_branch with redirect_pc=0x10, imm16=16'hFFFC → target 0x04. Both stale responses dropped (drop_cnt=2); next inst_pc=0x04.
- redirect_jump and redirect_branch together, redirect_pc=0x1000_0040, addr26=26'h0000100, imm16=5 → jump wins, target 0x1000_0400.
- fetch_pc=0xFFFF_FFF8 with sequential fetch → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- reset asserted mid-DRAIN with 2 responses outstanding → next cycle all outputs 0, fetch restarts at RESET_PC, no stale word reaches inst.
